// File: rtl/julia_pixel_writer.sv
// Captures Julia pixel colours on the shared iteration count, buffers them in a FIFO and
// drains them to the frame buffer over req/ack. Optional macro JULIA_BLACK_COUNT_EN adds black_count.
module julia_pixel_writer #(
  parameter int          H_RES         = 640,
  parameter int          V_RES         = 480,
  parameter int          FIFO_DEPTH    = 8,
  parameter logic [12:0] CAPTURE_COUNT = 13'd8191,
  parameter int          ADDR_W        = 19
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic [12:0]                   count,
  input  logic [7:0]                    red_in,
  input  logic [7:0]                    blue_in,
  output logic                          mem_wr_req,
  input  logic                          mem_wr_ack,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [15:0]                   mem_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_done
`ifdef JULIA_BLACK_COUNT_EN
  ,
  output logic [ADDR_W-1:0]             black_count
`endif
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                LVL_W     = PTR_W + 1;
  localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [15:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [ADDR_W-1:0] r_addr_cnt;

  logic              w_capture;
  logic              w_push;
  logic              w_drop;
  logic              w_empty;
  logic              w_pop;
  logic              w_load;
  logic              w_ack_take;
  logic              w_last_ack;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_load_addr;

  // A push is judged against the pre-edge level; a same-cycle pop cannot rescue it.
  assign w_capture   = (count == CAPTURE_COUNT);
  assign w_push      = w_capture && (fifo_level < DEPTH_L);
  assign w_drop      = w_capture && (fifo_level >= DEPTH_L);
  assign w_empty     = (fifo_level == '0);
  assign w_addr_inc  = (r_addr_cnt == LAST_ADDR) ? '0 : r_addr_cnt + 1'b1;
  assign w_load_addr = w_ack_take ? w_addr_inc : r_addr_cnt;
  assign w_last_ack  = w_ack_take && (r_addr_cnt == LAST_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_ack_take  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_wr_ack) begin
          w_ack_take = 1'b1;
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_load = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {red_in, blue_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      mem_wr_req <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      r_addr_cnt <= '0;
      frame_done <= 1'b0;
    end else if (clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      mem_wr_req <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      r_addr_cnt <= '0;
      frame_done <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      fifo_level <= fifo_level + LVL_W'(w_push) - LVL_W'(w_pop);
      if (w_drop) begin
        overflow <= 1'b1;
      end
      mem_wr_req <= (w_state_nxt == S_WRITE);
      if (w_load) begin
        mem_data <= r_fifo[r_rd_ptr];
        mem_addr <= w_load_addr;
      end
      if (w_ack_take) begin
        r_addr_cnt <= w_addr_inc;
      end
      frame_done <= w_last_ack;
    end
  end

`ifdef JULIA_BLACK_COUNT_EN
  logic [ADDR_W-1:0] r_black_acc;

  // The final pixel's ack is folded straight into the published total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_black_acc <= '0;
      black_count <= '0;
    end else if (clr) begin
      r_black_acc <= '0;
      black_count <= '0;
    end else if (w_last_ack) begin
      black_count <= r_black_acc + ADDR_W'(mem_data == 16'h0000);
      r_black_acc <= '0;
    end else if (w_ack_take && (mem_data == 16'h0000)) begin
      r_black_acc <= r_black_acc + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_julia_pixel_writer.sv
// Directed bench for julia_pixel_writer: a full-size instance for capture/FIFO/handshake
// and a 4x2 instance for frame wrap and the optional black pixel count.
module tb_julia_pixel_writer;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [12:0] count;
  logic [7:0]  red;
  logic [7:0]  blue;
  logic        ack;
  logic        ack_s;

  logic        req;
  logic [18:0] addr;
  logic [15:0] data;
  logic [3:0]  lvl;
  logic        ovf;
  logic        fd;

  logic        req_s;
  logic [2:0]  addr_s;
  logic [15:0] data_s;
  logic [3:0]  lvl_s;
  logic        ovf_s;
  logic        fd_s;

`ifdef JULIA_BLACK_COUNT_EN
  logic [18:0] bc;
  logic [2:0]  bc_s;
`endif

  int n_chk = 0;
  int n_err = 0;

  julia_pixel_writer dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .count      (count),
    .red_in     (red),
    .blue_in    (blue),
    .mem_wr_req (req),
    .mem_wr_ack (ack),
    .mem_addr   (addr),
    .mem_data   (data),
    .fifo_level (lvl),
    .overflow   (ovf),
    .frame_done (fd)
`ifdef JULIA_BLACK_COUNT_EN
    ,
    .black_count(bc)
`endif
  );

  julia_pixel_writer #(
    .H_RES (4),
    .V_RES (2),
    .ADDR_W(3)
  ) dut_s (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .count      (count),
    .red_in     (red),
    .blue_in    (blue),
    .mem_wr_req (req_s),
    .mem_wr_ack (ack_s),
    .mem_addr   (addr_s),
    .mem_data   (data_s),
    .fifo_level (lvl_s),
    .overflow   (ovf_s),
    .frame_done (fd_s)
`ifdef JULIA_BLACK_COUNT_EN
    ,
    .black_count(bc_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [15:0] d);
    count = 13'd8191;
    {red, blue} = d;
    tick();
    count = 13'd0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  logic [15:0] frame1 [8] = '{16'h0000, 16'h00FF, 16'h0000, 16'hFF00,
                              16'h0000, 16'h0000, 16'h1234, 16'h0000};
  logic [15:0] frame2 [8] = '{16'h0101, 16'h0000, 16'h0202, 16'h0303,
                              16'h0000, 16'h0404, 16'h0505, 16'h0606};

  initial begin
    rst   = 1'b0;
    clr   = 1'b0;
    count = 13'd0;
    red   = 8'h00;
    blue  = 8'h00;
    ack   = 1'b0;
    ack_s = 1'b0;
    tick();
    tick();
    chk("rst_req",   32'(req),  32'd0);
    chk("rst_addr",  32'(addr), 32'd0);
    chk("rst_data",  32'(data), 32'd0);
    chk("rst_level", 32'(lvl),  32'd0);
    chk("rst_ovf",   32'(ovf),  32'd0);
    chk("rst_fd",    32'(fd),   32'd0);

    // release reset at count=100 with a free-running count
    rst = 1'b1;
    for (int c = 100; c < 8191; c++) begin
      count = 13'(c);
      tick();
    end
    chk("pre_cap_req",   32'(req), 32'd0);
    chk("pre_cap_level", 32'(lvl), 32'd0);
    count = 13'd8191;
    red   = 8'hA5;
    blue  = 8'h3C;
    tick();
    count = 13'd0;
    red   = 8'h00;
    blue  = 8'h00;
    chk("cap_level", 32'(lvl), 32'd1);
    chk("cap_req",   32'(req), 32'd0);
    count = 13'd1;
    tick();
    chk("first_req",  32'(req),  32'd1);
    chk("first_addr", 32'(addr), 32'd0);
    chk("first_data", 32'(data), 32'hA53C);
    chk("first_lvl",  32'(lvl),  32'd0);
    count = 13'd2;
    tick();
    count = 13'd3;
    tick();
    chk("hold_req",  32'(req),  32'd1);
    chk("hold_addr", 32'(addr), 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_drop_req", 32'(req), 32'd0);
    capture(16'h1122);
    tick();
    chk("second_req",  32'(req),  32'd1);
    chk("second_addr", 32'(addr), 32'd1);
    chk("second_data", 32'(data), 32'h1122);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // overflow: nine captures fit, the tenth is dropped
    do_clr();
    chk("clr_addr", 32'(addr), 32'd0);
    chk("clr_req",  32'(req),  32'd0);
    for (int i = 0; i < 9; i++) capture({8'(8'h10 + i), 8'(8'h80 + i)});
    chk("nine_level", 32'(lvl),  32'd8);
    chk("nine_ovf",   32'(ovf),  32'd0);
    chk("nine_req",   32'(req),  32'd1);
    capture(16'hDEAD);
    chk("ten_ovf",   32'(ovf), 32'd1);
    chk("ten_level", 32'(lvl), 32'd8);
    ack = 1'b1;
    for (int j = 0; j < 9; j++) begin
      chk("drain_req",  32'(req),  32'd1);
      chk("drain_addr", 32'(addr), 32'(j));
      chk("drain_data", 32'(data), {16'd0, 8'(8'h10 + j), 8'(8'h80 + j)});
      tick();
    end
    ack = 1'b0;
    chk("drain_end_req", 32'(req), 32'd0);
    chk("drain_end_lvl", 32'(lvl), 32'd0);
    chk("ovf_sticky",    32'(ovf), 32'd1);

    // back-to-back writes with ack held high
    do_clr();
    chk("clr_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 4; i++) capture({8'(i), 8'(8'h40 + i)});
    chk("b2b_prefill_lvl", 32'(lvl), 32'd3);
    ack = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("b2b_req",  32'(req),  32'd1);
      chk("b2b_addr", 32'(addr), 32'(j));
      chk("b2b_data", 32'(data), {16'd0, 8'(j), 8'(8'h40 + j)});
      tick();
    end
    ack = 1'b0;
    chk("b2b_end_req", 32'(req), 32'd0);
    chk("b2b_end_lvl", 32'(lvl), 32'd0);

    // clr mid-handshake
    for (int i = 0; i < 4; i++) capture({8'hC0, 8'(i)});
    chk("midclr_addr_before", 32'(addr), 32'd4);
    chk("midclr_lvl_before",  32'(lvl),  32'd3);
    chk("midclr_req_before",  32'(req),  32'd1);
    do_clr();
    chk("midclr_req",  32'(req),  32'd0);
    chk("midclr_lvl",  32'(lvl),  32'd0);
    chk("midclr_ovf",  32'(ovf),  32'd0);
    chk("midclr_addr", 32'(addr), 32'd0);
    capture(16'hBEEF);
    tick();
    chk("postclr_req",  32'(req),  32'd1);
    chk("postclr_addr", 32'(addr), 32'd0);
    chk("postclr_data", 32'(data), 32'hBEEF);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // 4x2 frame: wrap, frame_done pulse, black count
    do_clr();
    for (int i = 0; i < 8; i++) capture(frame1[i]);
    chk("f1_lvl", 32'(lvl_s), 32'd7);
    ack_s = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("f1_addr", 32'(addr_s), 32'(j));
      chk("f1_data", 32'(data_s), 32'(frame1[j]));
      chk("f1_fd",   32'(fd_s),   32'd0);
      tick();
    end
    ack_s = 1'b0;
    chk("f1_done",     32'(fd_s),  32'd1);
    chk("f1_done_req", 32'(req_s), 32'd0);
`ifdef JULIA_BLACK_COUNT_EN
    chk("f1_black", 32'(bc_s), 32'd5);
`endif
    tick();
    chk("f1_done_pulse", 32'(fd_s), 32'd0);
    for (int i = 0; i < 8; i++) capture(frame2[i]);
    chk("f2_first_addr", 32'(addr_s), 32'd0);
    chk("f2_first_data", 32'(data_s), 32'h0101);
`ifdef JULIA_BLACK_COUNT_EN
    chk("f2_black_hold", 32'(bc_s), 32'd5);
`endif
    ack_s = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("f2_addr", 32'(addr_s), 32'(j));
      chk("f2_fd",   32'(fd_s),   32'd0);
      tick();
    end
    ack_s = 1'b0;
    chk("f2_done", 32'(fd_s), 32'd1);
`ifdef JULIA_BLACK_COUNT_EN
    chk("f2_black", 32'(bc_s), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
